// File: rtl/wb_ctrl_arb_pkg.sv
// Shared types and defaults for the Wishbone master sequencer / arbiter.
package wb_ctrl_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUS, DONE} wb_arb_state_e;

  localparam int WB_DATA_W  = 32;
  localparam int ADDR_W_DEF = 18;
  localparam int TMO_DEF    = 255;

  // Timeout counter width; never below one bit so TMO=1 still builds.
  function automatic int tmo_cnt_width(input int tmo);
    return (tmo <= 2) ? 1 : $clog2(tmo);
  endfunction

endpackage

// File: rtl/wb_ctrl_arb_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    // Offset NREQ lands back on last_grant, so it has lowest priority.
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(last_grant_i) + k) % NREQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/wb_ctrl_arb.sv
// Round-robin Wishbone master: one single-beat classic cycle per grant,
// done/err completion pulses and a saturating no-ack timeout.
module wb_ctrl_arb
  import wb_ctrl_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int TMO    = TMO_DEF
) (
  input  logic                        clk_i,
  input  logic                        wb_rst,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ-1:0]             req_we,
  input  logic [NREQ*ADDR_W-1:0]      req_addr,
  input  logic [NREQ*WB_DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]             done,
  output logic [NREQ-1:0]             err,
  output logic [WB_DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]           wb_addr_o,
  output logic [WB_DATA_W-1:0]        wb_data_o_m,
  output logic                        wb_we_o,
  output logic                        wb_stb_o,
  output logic                        wb_cyc_o,
  input  logic [WB_DATA_W-1:0]        wb_data_i_m,
  input  logic                        wb_ack_i,
  output logic                        busy
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = tmo_cnt_width(TMO);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO - 1);

  wb_arb_state_e        state_q;
  logic [IDX_W-1:0]     last_grant_q;
  logic [NREQ-1:0]      gnt_q;
  logic [CNT_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [ADDR_W-1:0]    addr_q;
  logic [WB_DATA_W-1:0] wdata_q;
  logic                 we_q;
  logic                 cyc_q;
  logic [NREQ-1:0]      done_q;
  logic [NREQ-1:0]      err_q;
  logic [WB_DATA_W-1:0] rdata_q;

  logic [ADDR_W-1:0]    addr_arr  [NREQ];
  logic [WB_DATA_W-1:0] wdata_arr [NREQ];
  logic [NREQ-1:0]      pick_gnt;
  logic [IDX_W-1:0]     pick_idx;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_wdata[gi*WB_DATA_W +: WB_DATA_W];
  end

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .gnt_o        (pick_gnt),
    .idx_o        (pick_idx)
  );

  always_comb begin
    tmo_cnt_d = (tmo_cnt_q == TMO_LAST) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge wb_rst) begin
    if (wb_rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NREQ - 1);
      gnt_q        <= '0;
      tmo_cnt_q    <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      cyc_q        <= 1'b0;
      done_q       <= '0;
      err_q        <= '0;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q      <= BUS;
            addr_q       <= addr_arr[pick_idx];
            wdata_q      <= wdata_arr[pick_idx];
            we_q         <= req_we[pick_idx];
            cyc_q        <= 1'b1;
            tmo_cnt_q    <= '0;
            last_grant_q <= pick_idx;
            gnt_q        <= pick_gnt;
          end
        end
        BUS: begin
          // Ack is tested first so a late ack beats a simultaneous timeout.
          if (wb_ack_i) begin
            state_q <= DONE;
            cyc_q   <= 1'b0;
            done_q  <= gnt_q;
            if (!we_q) begin
              rdata_q <= wb_data_i_m;
            end
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_q <= DONE;
            cyc_q   <= 1'b0;
            err_q   <= gnt_q;
            rdata_q <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= '0;
          err_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_addr_o   = addr_q;
  assign wb_data_o_m = wdata_q;
  assign wb_we_o     = we_q;
  assign wb_stb_o    = cyc_q;
  assign wb_cyc_o    = cyc_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_wb_ctrl_arb.sv
// Scoreboard bench for wb_ctrl_arb: a Wishbone slave model checks bus cycles,
// a monitor checks done/err/rdata pulses against queued expectations.
module tb_wb_ctrl_arb;

  localparam int NREQ   = 2;
  localparam int ADDR_W = 18;
  localparam int TB_TMO = 8;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic                   clk_i = 1'b0;
  logic                   wb_rst;
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*32-1:0]     req_wdata;
  logic [NREQ-1:0]        done;
  logic [NREQ-1:0]        err;
  logic [31:0]            rdata;
  logic [ADDR_W-1:0]      wb_addr_o;
  logic [31:0]            wb_data_o_m;
  logic                   wb_we_o;
  logic                   wb_stb_o;
  logic                   wb_cyc_o;
  logic [31:0]            wb_data_i_m = JUNK;
  logic                   wb_ack_i = 1'b0;
  logic                   busy;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    int                delay;   // wait states before ack; <0 means never ack
  } bus_t;

  typedef struct {
    int          idx;
    bit          is_err;
    logic [31:0] rdata;
  } resp_t;

  bus_t        bus_q[$];
  resp_t       resp_q[$];
  logic [31:0] hold_rdata = 32'h0;
  int          n_checks = 0;
  int          n_pass = 0;

  wb_ctrl_arb #(
    .NREQ   (NREQ),
    .ADDR_W (ADDR_W),
    .TMO    (TB_TMO)
  ) dut (
    .clk_i       (clk_i),
    .wb_rst      (wb_rst),
    .req         (req),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .done        (done),
    .err         (err),
    .rdata       (rdata),
    .wb_addr_o   (wb_addr_o),
    .wb_data_o_m (wb_data_o_m),
    .wb_we_o     (wb_we_o),
    .wb_stb_o    (wb_stb_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_data_i_m (wb_data_i_m),
    .wb_ack_i    (wb_ack_i),
    .busy        (busy)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic push_exp(input int idx, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rd, input int delay,
                          input bit with_resp);
    bus_t  b;
    resp_t r;
    b.addr = addr; b.we = we; b.wdata = wdata; b.rdata = rd; b.delay = delay;
    bus_q.push_back(b);
    if (with_resp) begin
      if (delay < 0) begin
        hold_rdata = 32'h0;
        r.is_err   = 1'b1;
      end else begin
        r.is_err = 1'b0;
        if (!we) hold_rdata = rd;
      end
      r.idx   = idx;
      r.rdata = hold_rdata;
      resp_q.push_back(r);
    end
  endtask

  task automatic set_payload(input int idx, input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [31:0] wdata);
    req_we[idx]                 = we;
    req_addr[idx*ADDR_W +: ADDR_W] = addr;
    req_wdata[idx*32 +: 32]      = wdata;
  endtask

  task automatic issue(input int idx, input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rd, input int delay);
    push_exp(idx, we, addr, wdata, rd, delay, 1'b1);
    set_payload(idx, we, addr, wdata);
    req[idx] = 1'b1;
  endtask

  task automatic wait_pulse(output int idx, output int lat);
    idx = -1;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      lat++;
      if ((done | err) != '0) begin
        idx = (done[1] | err[1]) ? 1 : 0;
        break;
      end
    end
    if (idx < 0) check("pulse_timeout", 32'd0, 32'd1);
  endtask

  // Wishbone slave model: acks after the queued number of wait states.
  bus_t cur;
  bit   active = 1'b0;
  int   cnt = 0;

  always @(negedge clk_i) begin
    if (wb_rst) begin
      active      = 1'b0;
      cnt         = 0;
      wb_ack_i    = 1'b0;
      wb_data_i_m = JUNK;
    end else if (wb_ack_i) begin
      wb_ack_i    = 1'b0;
      wb_data_i_m = JUNK;
      check("cyc_drop_on_ack", {31'd0, wb_cyc_o}, 32'd0);
      active = 1'b0;
    end else if (wb_cyc_o) begin
      if (!active) begin
        if (bus_q.size() == 0) begin
          check("unexpected_cycle", 32'd1, 32'd0);
          cur.addr = wb_addr_o; cur.we = wb_we_o; cur.wdata = wb_data_o_m;
          cur.rdata = JUNK; cur.delay = 0;
        end else begin
          cur = bus_q.pop_front();
        end
        active = 1'b1;
        cnt    = 0;
      end else begin
        cnt++;
      end
      check("stb", {31'd0, wb_stb_o}, 32'd1);
      check("addr", {14'd0, wb_addr_o}, {14'd0, cur.addr});
      check("we", {31'd0, wb_we_o}, {31'd0, cur.we});
      if (cur.we) check("wdata", wb_data_o_m, cur.wdata);
      if (cur.delay == cnt) begin
        wb_ack_i    = 1'b1;
        wb_data_i_m = cur.rdata;
      end
    end else if (active) begin
      check("cyc_len", cnt + 1, (cur.delay < 0) ? TB_TMO : cur.delay + 1);
      active = 1'b0;
    end
  end

  // Completion monitor.
  bit prev_pulse = 1'b0;

  always @(negedge clk_i) begin
    resp_t r;
    if ((done | err) != '0) begin
      check("pulse_width", {31'd0, prev_pulse}, 32'd0);
      if (resp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, done}, {30'd0, err});
      end else begin
        r = resp_q.pop_front();
        check("done", {30'd0, done}, r.is_err ? 32'd0 : (32'd1 << r.idx));
        check("err", {30'd0, err}, r.is_err ? (32'd1 << r.idx) : 32'd0);
        check("rdata", rdata, r.rdata);
        $display("txn: requester %0d %s rdata=0x%08h", r.idx, r.is_err ? "err" : "done", rdata);
      end
      prev_pulse = 1'b1;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  initial begin
    int idx, lat;
    wb_rst    = 1'b1;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk_i);
    check("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    check("rst_stb", {31'd0, wb_stb_o}, 32'd0);
    check("rst_done_err", {28'd0, done, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_addr", {14'd0, wb_addr_o}, 32'd0);
    wb_rst = 1'b0;
    @(negedge clk_i);

    // Single write, ack in the first BUS cycle.
    issue(0, 1'b1, 18'h00004, 32'hDEAD_BEEF, 32'h0, 0);
    wait_pulse(idx, lat);
    check("wr_latency", lat, 2);
    if (idx >= 0) req[idx] = 1'b0;
    @(negedge clk_i);

    // Single read with three wait states.
    issue(1, 1'b0, 18'h00010, 32'h0, 32'h1234_5678, 3);
    wait_pulse(idx, lat);
    check("rd_latency", lat, 5);
    if (idx >= 0) req[idx] = 1'b0;
    @(negedge clk_i);

    // Contention: both requesters held, expected order 0,1,0,1.
    push_exp(0, 1'b1, 18'h00100, 32'h1000_0000, 32'h0, 1, 1'b1);
    push_exp(1, 1'b1, 18'h00200, 32'h2000_0000, 32'h0, 0, 1'b1);
    push_exp(0, 1'b0, 18'h00104, 32'h0, 32'hCAFE_0001, 2, 1'b1);
    push_exp(1, 1'b1, 18'h00204, 32'h2000_0001, 32'h0, 0, 1'b1);
    set_payload(0, 1'b1, 18'h00100, 32'h1000_0000);
    set_payload(1, 1'b1, 18'h00200, 32'h2000_0000);
    req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_pulse(idx, lat);
      check("grant_order", idx, t % 2);
      if (idx >= 0) begin
        if (t == 0) set_payload(0, 1'b0, 18'h00104, 32'h0);
        else if (t == 1) set_payload(1, 1'b1, 18'h00204, 32'h2000_0001);
        else req[idx] = 1'b0;
      end
    end
    req = '0;
    @(negedge clk_i);

    // Timeout with no ack, then ack on the last allowed cycle.
    issue(1, 1'b0, 18'h00020, 32'h0, 32'h0, -1);
    wait_pulse(idx, lat);
    check("tmo_latency", lat, TB_TMO + 1);
    if (idx >= 0) req[idx] = 1'b0;
    @(negedge clk_i);
    issue(0, 1'b0, 18'h00024, 32'h0, 32'hA5A5_0008, TB_TMO - 1);
    wait_pulse(idx, lat);
    check("late_ack_latency", lat, TB_TMO + 1);
    if (idx >= 0) req[idx] = 1'b0;
    @(negedge clk_i);

    // Reset in the middle of a BUS cycle.
    push_exp(0, 1'b1, 18'h00030, 32'h3333_3333, 32'h0, -1, 1'b0);
    set_payload(0, 1'b1, 18'h00030, 32'h3333_3333);
    req[0] = 1'b1;
    repeat (3) @(negedge clk_i);
    check("pre_rst_cyc", {31'd0, wb_cyc_o}, 32'd1);
    #2 wb_rst = 1'b1;
    #1;
    check("async_rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    check("async_rst_stb", {31'd0, wb_stb_o}, 32'd0);
    check("async_rst_pulse", {28'd0, done, err}, 32'd0);
    hold_rdata = 32'h0;
    set_payload(0, 1'b1, 18'h00040, 32'h4444_4444);
    set_payload(1, 1'b1, 18'h00050, 32'h5555_5555);
    push_exp(0, 1'b1, 18'h00040, 32'h4444_4444, 32'h0, 0, 1'b1);
    push_exp(1, 1'b1, 18'h00050, 32'h5555_5555, 32'h0, 0, 1'b1);
    req = 2'b11;
    repeat (2) @(negedge clk_i);
    wb_rst = 1'b0;
    for (int t = 0; t < 2; t++) begin
      wait_pulse(idx, lat);
      check("post_rst_order", idx, t);
      if (idx >= 0) req[idx] = 1'b0;
    end

    repeat (4) @(negedge clk_i);
    check("bus_q_empty", bus_q.size(), 32'd0);
    check("resp_q_empty", resp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
